// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sweep sequencer: FSM encoding, vector sizing and
// the default expected table for Z = A&B | B&C.
package truth_pkg;

  localparam int unsigned VEC_W = 3;
  localparam int unsigned NVEC  = 8;

  // Bit i is Z for {A,B,C} = i; vectors 3, 6 and 7 drive Z high.
  localparam logic [NVEC-1:0] EXPECTED_DEFAULT = 8'hC8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_REPORT = 2'd2
  } state_e;

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Host/datapath-facing signal bundle for the sweep sequencer.
// The slave modport is the sequencer view; master is the host + datapath view.
interface truth_table_sequencer_if;
  import truth_pkg::*;

  logic             start;
  logic             z;
  logic             a;
  logic             b;
  logic             c;
  logic             busy;
  logic             done;
  logic [NVEC-1:0]  tbl;
  logic             pass;
  logic [3:0]       fail_cnt;
  logic [VEC_W-1:0] first_fail;

  modport master (
    output start, z,
    input  a, b, c, busy, done, tbl, pass, fail_cnt, first_fail
  );

  modport slave (
    input  start, z,
    output a, b, c, busy, done, tbl, pass, fail_cnt, first_fail
  );

endinterface

// File: rtl/truth_table_sequencer_hold_timer.sv
// 4-bit load/up/down counter flagging the last cycle of a HOLD-cycle window.
// Counting up it runs 0..HOLD-1; counting down it runs HOLD-1..0.
module hold_timer #(
  parameter int unsigned HOLD = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  input  logic i_down,
  output logic o_tc
);

  localparam logic [3:0] LastCnt = 4'(HOLD - 1);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_down ? LastCnt : 4'd0;
    end else if (i_en) begin
      r_cnt <= i_down ? (r_cnt - 4'd1) : (r_cnt + 4'd1);
    end
  end

  always_comb begin
    o_tc = i_down ? (r_cnt == 4'd0) : (r_cnt == LastCnt);
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Clocked sweep of all eight {A,B,C} vectors through an external gate datapath, capturing Z
// into an 8-bit truth table and comparing it against EXPECTED.
module truth_table_sequencer
  import truth_pkg::*;
#(
  parameter int unsigned     HOLD     = 4,
  parameter logic [NVEC-1:0] EXPECTED = EXPECTED_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  truth_table_sequencer_if.slave io_bus
);

  state_e           r_state;
  state_e           w_state_next;
  logic [VEC_W-1:0] r_idx;
  logic [NVEC-1:0]  r_tbl;
  logic [NVEC-1:0]  w_tbl_cap;
  logic [3:0]       r_fail_cnt;
  logic [VEC_W-1:0] r_first_fail;
  logic             r_pass;
  logic             w_tc;
  logic             w_start_sweep;
  logic             w_capture;
  logic             w_last;
  logic             w_mismatch;
  logic             w_busy;
  logic             w_done;

  assign w_start_sweep = (r_state == S_IDLE) && io_bus.start;
  assign w_capture     = (r_state == S_APPLY) && w_tc;
  assign w_last        = w_capture && (r_idx == 3'd7);
  assign w_mismatch    = (io_bus.z != EXPECTED[r_idx]);

  // Reloaded at sweep start and after every capture so each vector gets a full window.
  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_start_sweep || w_capture),
    .i_en    (r_state == S_APPLY),
    .i_down  (1'b0),
    .o_tc    (w_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (io_bus.start) w_state_next = S_APPLY;
      S_APPLY:  if (w_last) w_state_next = S_REPORT;
      S_REPORT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_APPLY:  w_busy = 1'b1;
      S_REPORT: w_done = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    w_tbl_cap        = r_tbl;
    w_tbl_cap[r_idx] = io_bus.z;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx        <= '0;
      r_tbl        <= '0;
      r_fail_cnt   <= 4'd0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
    end else if (w_start_sweep) begin
      r_idx        <= '0;
      r_tbl        <= '0;
      r_fail_cnt   <= 4'd0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
    end else if (w_capture) begin
      r_tbl <= w_tbl_cap;
      if (w_mismatch) begin
        r_fail_cnt <= r_fail_cnt + 4'd1;
        if (r_fail_cnt == 4'd0) begin
          r_first_fail <= r_idx;
        end
      end
      // Index returns to 0 on the final capture so A/B/C are idle-low during REPORT.
      if (r_idx == 3'd7) begin
        r_idx  <= '0;
        r_pass <= (w_tbl_cap == EXPECTED);
      end else begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  assign io_bus.a          = r_idx[2];
  assign io_bus.b          = r_idx[1];
  assign io_bus.c          = r_idx[0];
  assign io_bus.busy       = w_busy;
  assign io_bus.done       = w_done;
  assign io_bus.tbl        = r_tbl;
  assign io_bus.pass       = r_pass;
  assign io_bus.fail_cnt   = r_fail_cnt;
  assign io_bus.first_fail = r_first_fail;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: two sequencers (HOLD=4 and HOLD=1) swept with directed datapath faults.
module tb_truth_table_sequencer;
  import truth_pkg::*;

  typedef struct {
    logic [7:0] tbl;
    logic       pass;
    logic [3:0] fc;
    logic [2:0] ff;
    int         done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   z_mode = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q4[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  truth_table_sequencer_if bus4 ();
  truth_table_sequencer_if bus1 ();

  function automatic logic zf(input int m, input logic a, input logic b, input logic c);
    case (m)
      1:       return a & b;
      2:       return 1'b1;
      default: return (a & b) | (b & c);
    endcase
  endfunction

  assign bus4.z = zf(z_mode, bus4.a, bus4.b, bus4.c);
  assign bus1.z = zf(0, bus1.a, bus1.b, bus1.c);

  truth_table_sequencer #(
    .HOLD     (4),
    .EXPECTED (8'hC8)
  ) u_dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus4)
  );

  truth_table_sequencer #(
    .HOLD     (1),
    .EXPECTED (8'hC8)
  ) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop and compare on every DONE, including BUSY run length and DONE timing.
  initial begin
    int   blen;
    exp_t e;
    blen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        blen = 0;
      end else begin
        if (bus4.busy) blen++;
        if (bus4.done) begin
          if (q4.size() == 0) begin
            chk("dut4_unexpected_done", 1, 0);
          end else begin
            e = q4.pop_front();
            chk("dut4_tbl", int'(bus4.tbl), int'(e.tbl));
            chk("dut4_pass", int'(bus4.pass), int'(e.pass));
            chk("dut4_fail_cnt", int'(bus4.fail_cnt), int'(e.fc));
            chk("dut4_first_fail", int'(bus4.first_fail), int'(e.ff));
            chk("dut4_done_cycle", cyc, e.done_cyc);
            chk("dut4_busy_len", blen, 32);
          end
          blen = 0;
        end
      end
    end
  end

  initial begin
    int   blen;
    exp_t e;
    blen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        blen = 0;
      end else begin
        if (bus1.busy) blen++;
        if (bus1.done) begin
          if (q1.size() == 0) begin
            chk("dut1_unexpected_done", 1, 0);
          end else begin
            e = q1.pop_front();
            chk("dut1_tbl", int'(bus1.tbl), int'(e.tbl));
            chk("dut1_pass", int'(bus1.pass), int'(e.pass));
            chk("dut1_fail_cnt", int'(bus1.fail_cnt), int'(e.fc));
            chk("dut1_done_cycle", cyc, e.done_cyc);
            chk("dut1_busy_len", blen, 8);
          end
          blen = 0;
        end
      end
    end
  end

  // Called at a negedge; returns at the next negedge with cyc == k (the START sampling edge).
  task automatic sweep4(input int mode, input logic [7:0] t, input logic p,
                        input logic [3:0] fc, input logic [2:0] ff, output int k);
    exp_t e;
    z_mode = mode;
    bus4.start = 1'b1;
    k = cyc + 1;
    e.tbl = t; e.pass = p; e.fc = fc; e.ff = ff; e.done_cyc = k + 32;
    q4.push_back(e);
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  task automatic drain4(input int budget);
    int n;
    n = 0;
    while (q4.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("dut4_drain_pending", q4.size(), 0);
    q4.delete();
    @(negedge clk);
  endtask

  task automatic drain1(input int budget);
    int n;
    n = 0;
    while (q1.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("dut1_drain_pending", q1.size(), 0);
    q1.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int   k;
    exp_t e;
    bus4.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_tbl", int'(bus4.tbl), 0);
    chk("rst_pass", int'(bus4.pass), 0);
    chk("rst_busy_done", int'({bus4.busy, bus4.done}), 0);
    chk("rst_abc", int'({bus4.a, bus4.b, bus4.c}), 0);
    chk("rst_fail", int'({bus4.fail_cnt, bus4.first_fail}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct datapath: A/B/C step 0..7 every 4 cycles.
    sweep4(0, 8'hC8, 1'b1, 4'd0, 3'd0, k);
    for (int i = 0; i < 8; i++) begin
      repeat ((i == 0) ? 3 : 4) @(negedge clk);
      chk($sformatf("abc_vec%0d", i), int'({bus4.a, bus4.b, bus4.c}), i);
    end
    drain4(60);
    chk("pass_held_idle", int'(bus4.pass), 1);

    // B&C term stuck at 0.
    sweep4(1, 8'hC0, 1'b0, 4'd1, 3'd3, k);
    drain4(60);

    // START pulses mid-sweep are ignored.
    sweep4(0, 8'hC8, 1'b1, 4'd0, 3'd0, k);
    repeat (5) @(negedge clk);
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    repeat (14) @(negedge clk);
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    drain4(60);
    repeat (45) @(negedge clk);

    // Reset during vector 5 discards the partial sweep.
    sweep4(0, 8'hC8, 1'b1, 4'd0, 3'd0, k);
    repeat (21) @(negedge clk);
    chk("pre_rst_vec5", int'({bus4.a, bus4.b, bus4.c}), 5);
    rst_n = 1'b0;
    #1;
    q4.delete();
    chk("midrst_abc", int'({bus4.a, bus4.b, bus4.c}), 0);
    chk("midrst_busy", int'(bus4.busy), 0);
    chk("midrst_tbl", int'(bus4.tbl), 0);
    chk("midrst_fail", int'({bus4.pass, bus4.fail_cnt, bus4.first_fail}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep4(0, 8'hC8, 1'b1, 4'd0, 3'd0, k);
    chk("post_rst_vec0", int'({bus4.a, bus4.b, bus4.c}), 0);
    drain4(60);

    // Z tied high.
    sweep4(2, 8'hFF, 1'b0, 4'd5, 3'd0, k);
    drain4(60);

    // HOLD=1 with START held: back-to-back sweeps, DONE every 10 cycles.
    bus1.start = 1'b1;
    k = cyc + 1;
    for (int s = 0; s < 3; s++) begin
      e.tbl = 8'hC8; e.pass = 1'b1; e.fc = 4'd0; e.ff = 3'd0; e.done_cyc = k + 8 + 10 * s;
      q1.push_back(e);
    end
    repeat (11) @(negedge clk);
    chk("dut1_tbl_clear_s2", int'(bus1.tbl), 0);
    chk("dut1_busy_s2", int'(bus1.busy), 1);
    repeat (10) @(negedge clk);
    chk("dut1_tbl_clear_s3", int'(bus1.tbl), 0);
    repeat (8) @(negedge clk);
    bus1.start = 1'b0;
    drain1(30);
    repeat (15) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Sequencer for the three-input gate datapath (Z = A·B + B·C). On each START it drives A, B, C through all eight vectors 000..111, holds each vector for HOLD cycles so the datapath can settle, and samples Z. It builds an 8-bit captured truth table and compares it against a parameterised expected table. It sits between a test/control host and the combinational datapath instance, replacing hand-timed stimulus with a clocked, self-checking sweep.

## Interface
- HOLD, default 4: cycles each vector is held; Z is sampled on the last held cycle; legal range 1..15.
- EXPECTED, default 8'hC8: expected truth table, bit i = Z for {A,B,C} = i (for Z = AB + BC, bits 3, 6 and 7 are set).
- CLK  in  1  single clock, all state updates on its rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- START  in  1  request a sweep; sampled only in IDLE.
- Z  in  1  datapath output, combinational from A/B/C.
- A, B, C  out  1 each  registered datapath inputs, {A,B,C} = current vector index.
- BUSY  out  1  high from the first APPLY cycle through the last APPLY cycle.
- DONE  out  1  one-cycle pulse when the sweep completes.
- TABLE  out  8  captured truth table; holds its value until the next sweep starts.
- PASS  out  1  TABLE == EXPECTED; valid from DONE until the next START.
- FAIL_CNT  out  4  number of mismatching bits, 0..8.
- FIRST_FAIL  out  3  lowest mismatching index; 0 when FAIL_CNT == 0.

## Operation
- States: IDLE, APPLY, REPORT.
- IDLE
  - START = 1 → APPLY with idx = 0 and hold count = 0.
  - TABLE, FAIL_CNT and FIRST_FAIL clear on the same edge.
  - START = 0 → stay in IDLE.
- APPLY
  - Drive {A,B,C} = idx and increment the hold count each cycle.
  - When hold count == HOLD−1:
    - capture TABLE[idx] = Z;
    - if Z != EXPECTED[idx], increment FAIL_CNT;
    - if this is the first mismatch, set FIRST_FAIL = idx.
  - After the capture: if idx == 7, go to REPORT; otherwise idx+1 and hold count returns to 0.
- REPORT (one cycle)
  - DONE = 1 and PASS updates.
  - Always returns to IDLE; A/B/C return to 0.
- START while in APPLY or REPORT: ignored, not queued.
- START held high continuously: a new sweep begins in the first IDLE cycle after REPORT, giving back-to-back sweeps with one IDLE cycle between them.
- Width rules
  - idx is 3 bits and never wraps inside a sweep; the 7→0 transition happens only via IDLE.
  - Hold count is 4 bits.
  - FAIL_CNT saturates naturally at 8.
- Reset (RST_N low, any time, including mid-sweep) forces immediately:
  - state IDLE, idx 0, hold count 0;
  - A = B = C = 0, BUSY = 0, DONE = 0, TABLE = 0, PASS = 0, FAIL_CNT = 0, FIRST_FAIL = 0.
  - A partial table is discarded.

## Timing
- Edge numbering: START is sampled high at edge k.
  - Vector i is driven for cycles k+1+i·HOLD through k+(i+1)·HOLD.
  - Z for vector i is captured at edge k+(i+1)·HOLD.
  - DONE is high for the cycle after edge k+8·HOLD.
  - Total sweep latency: 8·HOLD+1 cycles from START to DONE.
- Z is treated as settling within HOLD cycles; HOLD = 1 samples in the same cycle the vector is presented.
- PASS is registered and updates on the REPORT entry edge, simultaneously with DONE rising.
- Outputs are registered; no combinational path from START or Z to any output.

## Structure
- Shared package/include `truth_pkg`:
  - state encodings S_IDLE = 2'd0, S_APPLY = 2'd1, S_REPORT = 2'd2;
  - VEC_W = 3, NVEC = 8;
  - default EXPECTED constant.
- One sub-module, `hold_timer`:
  - 4-bit down/up counter with load and terminal-count output;
  - parameterised by HOLD, reused by other sweep controllers.
- FSM, idx counter and result/compare logic live in the top module.
- The datapath is instantiated by the integrator, not inside this block.

## Test plan
- Reset then START pulse, HOLD = 4, correct datapath attached → A/B/C step 0..7 every 4 cycles; DONE at START+33; TABLE = 8'hC8, PASS = 1, FAIL_CNT = 0.
- Z replaced by the datapath with an AND stuck-at-0 on the B·C term → TABLE = 8'hC0, PASS = 0, FAIL_CNT = 1, FIRST_FAIL = 3.
- START pulsed again at sweep cycles 5 and 20 → no effect; single DONE at START+33; BUSY continuously high for 32 cycles.
- RST_N driven low during vector 5, then released, then START → all outputs 0 immediately on reset; new sweep starts from vector 0; TABLE is correct.
- HOLD = 1 with START held high → sweeps of 9 cycles each, one IDLE cycle between them; DONE every 10 cycles; TABLE re-cleared at each start.
- Z tied to 1 → TABLE = 8'hFF, FAIL_CNT = 5, FIRST_FAIL = 0, PASS = 0.
